lcd_bus_responder: RTL and testbench

LCD_BUS_RESPONDER -- requirements
Module: lcd_bus_responder

---
 rtl/lcd_bus_responder.sv | 175 +++++++++++++++++
 tb/tb_lcd_bus_responder.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_bus_responder.sv
// HD44780-style LCD bus responder: accepts asynchronous bus writes/reads from a
// master, keeps a 2x16 display buffer and models the controller busy flag.
module lcd_bus_responder #(
    parameter int BUSY_CYCLES  = 2000,
    parameter int CLEAR_CYCLES = 82000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       lcd_en,
    input  logic       lcd_rs,
    input  logic       lcd_rw,
    input  logic [7:0] lcd_data_in,
    output logic [7:0] lcd_data_out,
    output logic       lcd_data_oe,
    input  logic [4:0] rd_addr,
    output logic [7:0] rd_char,
    output logic       busy,
    output logic       display_on,
    output logic       err_overrun
);
    localparam int MAXC = (CLEAR_CYCLES > BUSY_CYCLES) ? CLEAR_CYCLES : BUSY_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] BUSY_LOAD  = CW'(BUSY_CYCLES - 1);
    localparam logic [CW-1:0] CLEAR_LOAD = CW'(CLEAR_CYCLES - 1);

    logic [1:0]    en_sync_q, rs_sync_q, rw_sync_q;
    logic [7:0]    data_sync0_q, data_sync1_q;
    logic          en_prev_q;

    logic [7:0]    buf_q [32];
    logic [7:0]    buf_d [32];
    logic [6:0]    ac_q, ac_d;
    logic          id_q, id_d;
    logic          disp_q, disp_d;
    logic          busy_q, busy_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          clr_active_q, clr_active_d;
    logic [4:0]    clr_idx_q, clr_idx_d;
    logic [7:0]    dout_q, dout_d;
    logic          oe_q, oe_d;
    logic          ovr_q, ovr_d;
    logic [7:0]    rd_char_q;

    logic          en_s, rs_s, rw_s;
    logic [7:0]    data_s;
    logic          en_rise, en_fall, wr_evt, wr_ok;

    assign en_s    = en_sync_q[1];
    assign rs_s    = rs_sync_q[1];
    assign rw_s    = rw_sync_q[1];
    assign data_s  = data_sync1_q;
    assign en_rise = en_s & ~en_prev_q;
    assign en_fall = ~en_s & en_prev_q;
    assign wr_evt  = en_fall & ~rw_s;
    assign wr_ok   = wr_evt & ~busy_q;

    function automatic logic [4:0] buf_idx(input logic [6:0] a);
        return {a[6], a[3:0]};
    endfunction

    // ac is always a valid address, so wrapping only depends on the low nibble.
    function automatic logic [6:0] next_ac(input logic [6:0] a, input logic inc);
        if (inc) begin
            if (a[3:0] == 4'hF) return {~a[6], 6'h00};
            return a + 7'd1;
        end
        if (a[3:0] == 4'h0) return {~a[6], 2'b00, 4'hF};
        return a - 7'd1;
    endfunction

    always_comb begin
        buf_d        = buf_q;
        ac_d         = ac_q;
        id_d         = id_q;
        disp_d       = disp_q;
        busy_d       = busy_q;
        cnt_d        = cnt_q;
        clr_active_d = clr_active_q;
        clr_idx_d    = clr_idx_q;
        dout_d       = dout_q;
        oe_d         = en_s & rw_s;
        ovr_d        = wr_evt & busy_q;

        if (busy_q) begin
            if (cnt_q == '0) busy_d = 1'b0;
            else             cnt_d  = cnt_q - 1'b1;
        end

        if (clr_active_q) begin
            buf_d[clr_idx_q] = 8'h20;
            clr_idx_d        = clr_idx_q + 5'd1;
            if (clr_idx_q == 5'd31) clr_active_d = 1'b0;
        end

        if (en_rise && rw_s)
            dout_d = rs_s ? buf_q[buf_idx(ac_q)] : {busy_q, ac_q};
        if (en_fall && rw_s && rs_s)
            ac_d = next_ac(ac_q, id_q);

        if (wr_ok) begin
            busy_d = 1'b1;
            cnt_d  = BUSY_LOAD;
            if (rs_s) begin
                buf_d[buf_idx(ac_q)] = data_s;
                ac_d = next_ac(ac_q, id_q);
            end else if (data_s[7]) begin
                ac_d = (data_s[5:4] == 2'b00) ? data_s[6:0] : 7'h00;
            end else if (data_s[6:4] != 3'b000) begin
                ac_d = ac_q;
            end else if (data_s[3]) begin
                disp_d = data_s[2];
            end else if (data_s[2]) begin
                id_d = data_s[1];
            end else if (data_s[1]) begin
                ac_d = 7'h00;
            end else if (data_s[0]) begin
                ac_d         = 7'h00;
                id_d         = 1'b1;
                cnt_d        = CLEAR_LOAD;
                clr_active_d = 1'b1;
                clr_idx_d    = 5'd0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            en_sync_q    <= '0;
            rs_sync_q    <= '0;
            rw_sync_q    <= '0;
            data_sync0_q <= '0;
            data_sync1_q <= '0;
            en_prev_q    <= 1'b0;
            for (int i = 0; i < 32; i++) buf_q[i] <= 8'h20;
            ac_q         <= 7'h00;
            id_q         <= 1'b1;
            disp_q       <= 1'b0;
            busy_q       <= 1'b0;
            cnt_q        <= '0;
            clr_active_q <= 1'b0;
            clr_idx_q    <= '0;
            dout_q       <= 8'h00;
            oe_q         <= 1'b0;
            ovr_q        <= 1'b0;
            rd_char_q    <= 8'h20;
        end else begin
            en_sync_q    <= {en_sync_q[0], lcd_en};
            rs_sync_q    <= {rs_sync_q[0], lcd_rs};
            rw_sync_q    <= {rw_sync_q[0], lcd_rw};
            data_sync0_q <= lcd_data_in;
            data_sync1_q <= data_sync0_q;
            en_prev_q    <= en_s;
            buf_q        <= buf_d;
            ac_q         <= ac_d;
            id_q         <= id_d;
            disp_q       <= disp_d;
            busy_q       <= busy_d;
            cnt_q        <= cnt_d;
            clr_active_q <= clr_active_d;
            clr_idx_q    <= clr_idx_d;
            dout_q       <= dout_d;
            oe_q         <= oe_d;
            ovr_q        <= ovr_d;
            rd_char_q    <= buf_q[rd_addr];
        end
    end

    assign lcd_data_out = dout_q;
    assign lcd_data_oe  = oe_q;
    assign rd_char      = rd_char_q;
    assign busy         = busy_q;
    assign display_on   = disp_q;
    assign err_overrun  = ovr_q;

endmodule

// File: tb/tb_lcd_bus_responder.sv
// Directed plus randomized bench for lcd_bus_responder against a row/column
// model of the display controller.
module tb_lcd_bus_responder;
    localparam int BUSY_CYC  = 20;
    localparam int CLEAR_CYC = 300;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       lcd_en = 1'b0, lcd_rs = 1'b0, lcd_rw = 1'b0;
    logic [7:0] lcd_data_in = 8'h00;
    logic [7:0] lcd_data_out;
    logic       lcd_data_oe;
    logic [4:0] rd_addr = 5'd0;
    logic [7:0] rd_char;
    logic       busy, display_on, err_overrun;

    lcd_bus_responder #(.BUSY_CYCLES(BUSY_CYC), .CLEAR_CYCLES(CLEAR_CYC)) dut (
        .clk(clk), .reset_n(reset_n), .lcd_en(lcd_en), .lcd_rs(lcd_rs),
        .lcd_rw(lcd_rw), .lcd_data_in(lcd_data_in), .lcd_data_out(lcd_data_out),
        .lcd_data_oe(lcd_data_oe), .rd_addr(rd_addr), .rd_char(rd_char),
        .busy(busy), .display_on(display_on), .err_overrun(err_overrun)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int run_len = 0;
    int last_run = 0;
    int ovr_cnt = 0;
    int exp_ovr = 0;

    // busy pulse width and overrun pulse count, sampled on the falling edge
    always @(negedge clk) begin
        if (!reset_n) begin
            run_len = 0;
        end else if (busy) begin
            run_len++;
        end else if (run_len != 0) begin
            last_run = run_len;
            run_len  = 0;
        end
        if (reset_n && err_overrun) ovr_cnt++;
    end

    // reference model: display as rows/columns
    logic [7:0] m_buf [32];
    int         m_row, m_col, m_a;
    logic       m_inc, m_disp;
    logic [7:0] exp_q [$];

    logic [7:0] rd_d;
    logic       rd_hi, rd_lo, r_rs;
    logic [7:0] r_v;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] m_ac();
        return 7'(m_row * 64 + m_col);
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 32; i++) m_buf[i] = 8'h20;
        m_row = 0; m_col = 0; m_inc = 1'b1; m_disp = 1'b0;
    endtask

    task automatic m_adv();
        if (m_inc) begin
            m_col++;
            if (m_col == 16) begin m_col = 0; m_row = 1 - m_row; end
        end else begin
            m_col--;
            if (m_col < 0) begin m_col = 15; m_row = 1 - m_row; end
        end
    endtask

    task automatic m_apply(input logic rs, input logic [7:0] v);
        if (rs) begin
            m_buf[m_row * 16 + m_col] = v;
            m_adv();
        end else if (v >= 8'h80) begin
            m_a = int'(v) - 128;
            if (m_a < 16) begin m_row = 0; m_col = m_a; end
            else if (m_a >= 64 && m_a < 80) begin m_row = 1; m_col = m_a - 64; end
            else begin m_row = 0; m_col = 0; end
        end else if (v >= 8'h10) begin
            m_a = 0;
        end else if (v >= 8'h08) begin
            m_disp = v[2];
        end else if (v >= 8'h04) begin
            m_inc = v[1];
        end else if (v >= 8'h02) begin
            m_row = 0; m_col = 0;
        end else if (v == 8'h01) begin
            for (int i = 0; i < 32; i++) m_buf[i] = 8'h20;
            m_row = 0; m_col = 0; m_inc = 1'b1;
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_write(input logic rs, input logic [7:0] v);
        @(negedge clk); #2;
        lcd_rs = rs; lcd_rw = 1'b0; lcd_data_in = v; lcd_en = 1'b1;
        cycles($urandom_range(3, 6));
        #1 lcd_en = 1'b0;
        cycles(4);
    endtask

    task automatic bus_read(input logic rs, output logic [7:0] d, output logic oe_hi, output logic oe_lo);
        @(negedge clk); #3;
        lcd_rs = rs; lcd_rw = 1'b1; lcd_en = 1'b1;
        cycles(5);
        d = lcd_data_out; oe_hi = lcd_data_oe;
        #2 lcd_en = 1'b0;
        cycles(4);
        oe_lo = lcd_data_oe;
        lcd_rw = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy === 1'b1 && n < CLEAR_CYC + 100) begin
            @(negedge clk); n++;
        end
        check("busy_timeout", {31'd0, busy}, 32'd0);
        cycles(2);
    endtask

    task automatic do_write(input logic rs, input logic [7:0] v);
        wait_idle();
        bus_write(rs, v);
        m_apply(rs, v);
    endtask

    task automatic check_ac();
        wait_idle();
        bus_read(1'b0, rd_d, rd_hi, rd_lo);
        check("ac_read", rd_d, {1'b0, m_ac()});
        check("oe_high", rd_hi, 1);
        check("oe_low", rd_lo, 0);
    endtask

    task automatic check_buffer(input string tag);
        for (int a = 0; a < 32; a++) begin
            @(negedge clk); rd_addr = 5'(a);
            exp_q.push_back(m_buf[a]);
            cycles(2);
            check(tag, rd_char, exp_q.pop_front());
        end
    endtask

    initial begin
        m_reset();
        cycles(3);
        check("rst_busy", busy, 0);
        check("rst_disp", display_on, 0);
        check("rst_ovr", err_overrun, 0);
        check("rst_oe", lcd_data_oe, 0);
        check("rst_dout", lcd_data_out, 0);
        #2 reset_n = 1'b1;
        cycles(2);
        check_buffer("rst_buf");

        // cursor home, two characters, busy width
        do_write(1'b0, 8'h80);
        do_write(1'b1, 8'h48);
        do_write(1'b1, 8'h49);
        wait_idle();
        check("busy_width", last_run, BUSY_CYC);
        check_ac();
        check_buffer("hi_buf");

        // row 0 -> row 1 wrap on increment
        do_write(1'b0, 8'h8F);
        do_write(1'b1, 8'h41);
        check_ac();
        do_write(1'b1, 8'h41);
        check_buffer("wrap_buf");

        // clear with an overrun write during its busy time
        wait_idle();
        bus_write(1'b0, 8'h01);
        m_apply(1'b0, 8'h01);
        check("clr_busy", busy, 1);
        cycles(100);
        bus_write(1'b1, 8'h77);
        exp_ovr++;
        cycles(2);
        check("ovr_pulse", ovr_cnt, exp_ovr);
        check_buffer("clr_buf");
        wait_idle();
        check("clr_width", last_run, CLEAR_CYC);
        check_ac();

        // display on, decrement mode, row 1 -> row 0 wrap
        do_write(1'b0, 8'h0C);
        wait_idle();
        check("disp_on", display_on, m_disp);
        do_write(1'b0, 8'h04);
        do_write(1'b0, 8'hC0);
        do_write(1'b1, 8'h5A);
        check_ac();
        check_buffer("dec_buf");

        // read while busy reports busy bit and ac
        do_write(1'b0, 8'h85);
        bus_read(1'b0, rd_d, rd_hi, rd_lo);
        check("rd_busy", rd_d, {1'b1, m_ac()});

        // data read returns buffer and moves ac
        do_write(1'b0, 8'hC0);
        wait_idle();
        bus_read(1'b1, rd_d, rd_hi, rd_lo);
        check("data_read", rd_d, m_buf[m_row * 16 + m_col]);
        m_adv();
        check_ac();

        // randomized traffic
        for (int n = 0; n < 40; n++) begin
            r_rs = 1'($urandom_range(0, 1));
            if (r_rs) begin
                r_v = 8'($urandom_range(0, 255));
            end else begin
                case ($urandom_range(0, 4))
                    0: r_v = 8'h80 | 8'($urandom_range(0, 127));
                    1: r_v = 8'($urandom_range(2, 3));
                    2: r_v = 8'($urandom_range(4, 7));
                    3: r_v = 8'($urandom_range(8, 15));
                    default: r_v = 8'($urandom_range(16, 127));
                endcase
            end
            do_write(r_rs, r_v);
            if (n % 8 == 7) begin
                check_ac();
                check("rand_disp", display_on, m_disp);
            end
        end
        check_buffer("rand_buf");
        check("no_spurious_ovr", ovr_cnt, exp_ovr);

        // reset in the middle of a clear
        wait_idle();
        bus_write(1'b0, 8'h01);
        cycles(6);
        #3 reset_n = 1'b0;
        #1;
        check("mid_busy", busy, 0);
        check("mid_disp", display_on, 0);
        check("mid_ovr", err_overrun, 0);
        check("mid_oe", lcd_data_oe, 0);
        check("mid_dout", lcd_data_out, 0);
        cycles(3);
        #2 reset_n = 1'b1;
        m_reset();
        cycles(3);
        check("post_busy", busy, 0);
        check_buffer("post_buf");
        check_ac();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $fatal(1, "FAIL watchdog: simulation did not complete");
    end
endmodule
